regfile_write_arbiter: RTL and testbench

Shares the single write port of the 8 x 8-bit register file between two writeback sources: the ALU result path and the memory-load path. Each source has a one-entry pending slot with a valid/ready handshake. Round-robin arbitration resolves conflicts, and same-destination writes are kept in arrival order. The block also gives decode per-read-port hazard flags, so an instruction cannot read a register that still has a write queued here.

---
 rtl/regfile_write_arbiter.sv | 163 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 8 x 8-bit register file: one pending slot each for the
// ALU and load writeback paths, round-robin on conflicts, arrival order on same dest.
module regfile_write_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       aluValid,
  output logic       aluReady,
  input  logic [2:0] aluDest,
  input  logic [7:0] aluData,
  input  logic       memValid,
  output logic       memReady,
  input  logic [2:0] memDest,
  input  logic [7:0] memData,
  input  logic [2:0] rsAddr,
  input  logic [2:0] rdAddr,
  output logic       rsHazard,
  output logic       rdHazard,
  output logic       writeEn,
  output logic [2:0] dest,
  output logic [7:0] data,
  output logic       grantMem
);

  logic       alu_full_r;
  logic [2:0] alu_dest_r;
  logic [7:0] alu_data_r;
  logic       mem_full_r;
  logic [2:0] mem_dest_r;
  logic [7:0] mem_data_r;
  logic       prio_r;
  logic       mem_older_r;

  logic       grant_alu_s;
  logic       grant_mem_s;
  logic       alu_acc_s;
  logic       mem_acc_s;
  logic       prio_next_s;
  logic       mem_older_next_s;

  function automatic logic slot_hit(input logic full, input logic [2:0] slot_dest,
                                    input logic [2:0] addr);
    slot_hit = full && (slot_dest == addr);
  endfunction

  // Grant selection from slot state only
  always_comb begin
    grant_alu_s = 1'b0;
    grant_mem_s = 1'b0;
    case ({alu_full_r, mem_full_r})
      2'b10: begin
        grant_alu_s = 1'b1;
        grant_mem_s = 1'b0;
      end
      2'b01: begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b1;
      end
      2'b11: begin
        // Same destination must retire in arrival order, otherwise round-robin
        if (alu_dest_r == mem_dest_r) begin
          grant_mem_s = mem_older_r;
          grant_alu_s = !mem_older_r;
        end else begin
          grant_mem_s = prio_r;
          grant_alu_s = !prio_r;
        end
      end
      default: begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
      end
    endcase
  end

  // Write port and handshake outputs
  always_comb begin
    writeEn  = grant_alu_s || grant_mem_s;
    grantMem = grant_mem_s;
    aluReady = !alu_full_r || grant_alu_s;
    memReady = !mem_full_r || grant_mem_s;
    if (grant_mem_s) begin
      dest = mem_dest_r;
      data = mem_data_r;
    end else if (grant_alu_s) begin
      dest = alu_dest_r;
      data = alu_data_r;
    end else begin
      dest = 3'd0;
      data = 8'h00;
    end
  end

  // Read-port hazard flags; a slot being written still counts until the edge
  always_comb begin
    rsHazard = slot_hit(alu_full_r, alu_dest_r, rsAddr) || slot_hit(mem_full_r, mem_dest_r, rsAddr);
    rdHazard = slot_hit(alu_full_r, alu_dest_r, rdAddr) || slot_hit(mem_full_r, mem_dest_r, rdAddr);
  end

  // Accept, priority and age next-state
  always_comb begin
    alu_acc_s        = aluValid && aluReady;
    mem_acc_s        = memValid && memReady;
    prio_next_s      = prio_r;
    mem_older_next_s = mem_older_r;
    if (alu_full_r && mem_full_r && (alu_dest_r != mem_dest_r)) begin
      prio_next_s = !prio_r;
    end else begin
      prio_next_s = prio_r;
    end
    // The age bit only matters while both slots are full; a lone new entry is younger
    if (alu_acc_s && mem_acc_s) begin
      mem_older_next_s = 1'b1;
    end else if (mem_acc_s) begin
      mem_older_next_s = 1'b0;
    end else if (alu_acc_s) begin
      mem_older_next_s = 1'b1;
    end else begin
      mem_older_next_s = mem_older_r;
    end
  end

  // ALU slot register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_full_r <= 1'b0;
      alu_dest_r <= 3'd0;
      alu_data_r <= 8'h00;
    end else if (alu_acc_s) begin
      alu_full_r <= 1'b1;
      alu_dest_r <= aluDest;
      alu_data_r <= aluData;
    end else if (grant_alu_s) begin
      alu_full_r <= 1'b0;
    end
  end

  // Load slot register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_full_r <= 1'b0;
      mem_dest_r <= 3'd0;
      mem_data_r <= 8'h00;
    end else if (mem_acc_s) begin
      mem_full_r <= 1'b1;
      mem_dest_r <= memDest;
      mem_data_r <= memData;
    end else if (grant_mem_s) begin
      mem_full_r <= 1'b0;
    end
  end

  // Round-robin priority and relative age
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_r      <= 1'b0;
      mem_older_r <= 1'b0;
    end else begin
      prio_r      <= prio_next_s;
      mem_older_r <= mem_older_next_s;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed test-plan steps then randomized traffic,
// checked against a sequence-number reference model and a shadow register file.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       aluValid, aluReady, memValid, memReady;
  logic [2:0] aluDest, memDest, rsAddr, rdAddr, dest;
  logic [7:0] aluData, memData, data;
  logic       rsHazard, rdHazard, writeEn, grantMem;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluReady(aluReady), .aluDest(aluDest), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memDest(memDest), .memData(memData),
    .rsAddr(rsAddr), .rdAddr(rdAddr), .rsHazard(rsHazard), .rdHazard(rdHazard),
    .writeEn(writeEn), .dest(dest), .data(data), .grantMem(grantMem)
  );

  // Shadow register file fed from the DUT write port
  logic [7:0] rf [8] = '{default: 8'h00};
  always @(posedge clk) if (writeEn) rf[dest] <= data;

  typedef struct { bit v; logic [2:0] d; logic [7:0] x; int seq; } ent_t;
  ent_t       ma, mm;
  bit         mprio;
  int         seqc;
  logic [7:0] mreg [8];

  int errors = 0;
  int checks = 0;
  bit acc_a, acc_m;
  logic       obs_we, obs_gm, obs_ar, obs_mr, obs_rsh, obs_rdh;
  logic [2:0] obs_dest;
  logic [7:0] obs_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ma = '{v: 1'b0, d: 3'd0, x: 8'h00, seq: 0};
    mm = '{v: 1'b0, d: 3'd0, x: 8'h00, seq: 0};
    mprio = 1'b0;
  endtask

  // 0 = idle, 1 = ALU, 2 = load
  function automatic int model_grant();
    if (!ma.v && !mm.v) return 0;
    if (ma.v && !mm.v) return 1;
    if (!ma.v) return 2;
    if (ma.d == mm.d) return (ma.seq < mm.seq) ? 1 : 2;
    return mprio ? 2 : 1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, writeEn, 1'b0);
    chk({tag, "_dest"}, dest, 3'd0);
    chk({tag, "_data"}, data, 8'h00);
    chk({tag, "_gm"}, grantMem, 1'b0);
    chk({tag, "_ar"}, aluReady, 1'b1);
    chk({tag, "_mr"}, memReady, 1'b1);
    chk({tag, "_rsh"}, rsHazard, 1'b0);
    chk({tag, "_rdh"}, rdHazard, 1'b0);
  endtask

  task automatic step(input bit av, input logic [2:0] ad, input logic [7:0] ax,
                      input bit mv, input logic [2:0] md, input logic [7:0] mx,
                      input logic [2:0] rs, input logic [2:0] rd);
    int g;
    bit ear, emr, ersh, erdh;
    @(negedge clk);
    aluValid = av; aluDest = ad; aluData = ax;
    memValid = mv; memDest = md; memData = mx;
    rsAddr = rs; rdAddr = rd;
    #1;
    g    = model_grant();
    ear  = !ma.v || g == 1;
    emr  = !mm.v || g == 2;
    ersh = (ma.v && ma.d == rs) || (mm.v && mm.d == rs);
    erdh = (ma.v && ma.d == rd) || (mm.v && mm.d == rd);
    obs_we = writeEn; obs_gm = grantMem; obs_ar = aluReady; obs_mr = memReady;
    obs_rsh = rsHazard; obs_rdh = rdHazard; obs_dest = dest; obs_data = data;
    chk("we", writeEn, g != 0);
    chk("gm", grantMem, g == 2);
    chk("dest", dest, g == 1 ? ma.d : (g == 2 ? mm.d : 3'd0));
    chk("data", data, g == 1 ? ma.x : (g == 2 ? mm.x : 8'h00));
    chk("alu_ready", aluReady, ear);
    chk("mem_ready", memReady, emr);
    chk("rs_hazard", rsHazard, ersh);
    chk("rd_hazard", rdHazard, erdh);
    // Advance the model across the edge
    if (g == 1) begin mreg[ma.d] = ma.x; end
    if (g == 2) begin mreg[mm.d] = mm.x; end
    if (ma.v && mm.v && ma.d != mm.d) mprio = !mprio;
    if (g == 1) ma.v = 1'b0;
    if (g == 2) mm.v = 1'b0;
    acc_a = av && ear;
    acc_m = mv && emr;
    if (acc_m) begin mm = '{v: 1'b1, d: md, x: mx, seq: seqc}; seqc++; end
    if (acc_a) begin ma = '{v: 1'b1, d: ad, x: ax, seq: seqc}; seqc++; end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [2:0] rs, input logic [2:0] rd);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, rs, rd);
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) chk(tag, rf[i], mreg[i]);
  endtask

  bit         pa, pm;
  logic [2:0] pad, pmd;
  logic [7:0] pax, pmx;

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    seqc = 1;
    model_reset();
    reset = 1'b1;
    aluValid = 1'b0; aluDest = 3'd0; aluData = 8'h00;
    memValid = 1'b0; memDest = 3'd0; memData = 8'h00;
    rsAddr = 3'd0; rdAddr = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Single write
    step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    chk("single_ar_at_accept", obs_ar, 1'b1);
    idle(3'd0, 3'd0);
    chk("single_we", obs_we, 1'b1);
    chk("single_dest", obs_dest, 3'd3);
    chk("single_data", obs_data, 8'h5A);
    chk("single_gm", obs_gm, 1'b0);
    chk("single_ar", obs_ar, 1'b1);
    chk("single_r3", rf[3], 8'h5A);

    // Conflict, different destinations, twice
    step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    chk("conf1_dest", obs_dest, 3'd1);
    chk("conf1_mr", obs_mr, 1'b0);
    idle(3'd0, 3'd0);
    chk("conf1b_dest", obs_dest, 3'd2);
    chk("conf1b_gm", obs_gm, 1'b1);
    step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    chk("conf2_gm", obs_gm, 1'b1);
    chk("conf2_dest", obs_dest, 3'd2);
    chk("conf2_ar", obs_ar, 1'b0);
    idle(3'd0, 3'd0);
    chk("conf2b_dest", obs_dest, 3'd1);

    // Same destination on the same edge: load first, ALU value lands last
    step(1'b1, 3'd4, 8'hAA, 1'b1, 3'd4, 8'hBB, 3'd0, 3'd0);
    idle(3'd4, 3'd0);
    chk("same_gm", obs_gm, 1'b1);
    chk("same_data", obs_data, 8'hBB);
    chk("same_rsh", obs_rsh, 1'b1);
    idle(3'd0, 3'd0);
    chk("same2_data", obs_data, 8'hAA);
    chk("same2_gm", obs_gm, 1'b0);
    chk("same_r4", rf[4], 8'hAA);
    // prio unchanged by the same-dest pair, so the ALU wins the next conflict
    step(1'b1, 3'd6, 8'h61, 1'b1, 3'd7, 8'h71, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    chk("prio_kept_gm", obs_gm, 1'b0);
    idle(3'd0, 3'd0);

    // Hazard on rs only
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h33, 3'd5, 3'd6);
    idle(3'd5, 3'd6);
    chk("haz_rs", obs_rsh, 1'b1);
    chk("haz_rd", obs_rdh, 1'b0);
    chk("haz_we", obs_we, 1'b1);
    idle(3'd5, 3'd6);
    chk("haz_rs_after", obs_rsh, 1'b0);

    // Streaming ALU writes
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'(i), 8'h10 + 8'(i), 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
      chk("stream_ar", obs_ar, 1'b1);
      if (i > 0) chk("stream_we", obs_we, 1'b1);
    end
    idle(3'd0, 3'd0);
    chk("stream_last_data", obs_data, 8'h13);
    for (int i = 0; i < 4; i++) chk("stream_reg", rf[i], 8'h10 + 8'(i));
    chk_regs("regs_directed");

    // Reset with both slots full
    step(1'b1, 3'd6, 8'h66, 1'b1, 3'd7, 8'h77, 3'd6, 3'd7);
    @(negedge clk);
    aluValid = 1'b0; memValid = 1'b0;
    rsAddr = 3'd6; rdAddr = 3'd7;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(3'd6, 3'd7);
    chk("post_reset_we", obs_we, 1'b0);
    idle(3'd6, 3'd7);
    chk("post_reset_r6", rf[6], 8'h61);
    chk("post_reset_r7", rf[7], 8'h71);

    // Randomized traffic; sources hold requests until accepted
    pa = 1'b0; pm = 1'b0;
    pad = 3'd0; pmd = 3'd0; pax = 8'h00; pmx = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1'b1; pad = 3'($urandom_range(0, 3)); pax = 8'($urandom);
      end
      if (!pm && $urandom_range(0, 3) != 0) begin
        pm = 1'b1; pmd = 3'($urandom_range(0, 3)); pmx = 8'($urandom);
      end
      step(pa, pad, pax, pm, pmd, pmx, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if (acc_a) pa = 1'b0;
      if (acc_m) pm = 1'b0;
    end
    repeat (3) idle(3'd0, 3'd0);
    chk_regs("regs_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
